// File: rtl/sqrt_iter_ctrl_pkg.sv
// Shared encodings and FP constants for the
// Babylonian square-root sequencer.
package sqrt_iter_ctrl_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F800000;
  localparam logic [31:0] FP_TWO  = 32'h40000000;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_EPS_DEFAULT = 32'h358637BD;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLASS,
    S_SUB,
    S_CHECK,
    S_ADD,
    S_HALF,
    S_RECIP,
    S_DONE
  } ctrl_state_e;

  typedef enum logic [1:0] {
    H_IDLE,
    H_ISSUE,
    H_WAIT
  } hs_state_e;

  function automatic logic mag_le(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return a[30:0] <= b[30:0];
  endfunction

endpackage

// File: rtl/sqrt_iter_ctrl_if.sv
// Two-operand stb/ack handshake to a shared
// FP unit; master = sequencer, slave = unit.
interface sqrt_iter_ctrl_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] z;
  logic a_stb;
  logic b_stb;
  logic a_ack;
  logic b_ack;
  logic z_stb;
  logic z_ack;

  modport master (
    output a, b, a_stb, b_stb, z_ack,
    input  a_ack, b_ack, z, z_stb
  );

  modport slave (
    input  a, b, a_stb, b_stb, z_ack,
    output a_ack, b_ack, z, z_stb
  );
endinterface

// File: rtl/sqrt_iter_ctrl_fp_hs_port.sv
// Issue/wait handshake for one FP unit:
// go launches an op, rdy pulses with result.
module fp_hs_port
  import sqrt_iter_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        go_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        rdy_o,
  sqrt_iter_ctrl_if.master u
);

  hs_state_e   state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic        a_stb_q;
  logic        b_stb_q;
  logic        rdy_q;
  logic        a_done;
  logic        b_done;

  // an operand counts as delivered once acked
  assign a_done = !a_stb_q || u.a_ack;
  assign b_done = !b_stb_q || u.b_ack;

  assign u.a      = a_q;
  assign u.b      = b_q;
  assign u.a_stb  = a_stb_q;
  assign u.b_stb  = b_stb_q;
  assign u.z_ack  = (state_q == H_WAIT);
  assign result_o = res_q;
  assign rdy_o    = rdy_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= H_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      a_stb_q <= 1'b0;
      b_stb_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      unique case (state_q)
        H_IDLE: begin
          if (go_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            a_stb_q <= 1'b1;
            b_stb_q <= 1'b1;
            state_q <= H_ISSUE;
          end
        end
        H_ISSUE: begin
          if (u.a_ack) a_stb_q <= 1'b0;
          if (u.b_ack) b_stb_q <= 1'b0;
          if (a_done && b_done) state_q <= H_WAIT;
        end
        H_WAIT: begin
          if (u.z_stb) begin
            res_q   <= u.z;
            rdy_q   <= 1'b1;
            state_q <= H_IDLE;
          end
        end
        default: state_q <= H_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sqrt_iter_ctrl.sv
// Babylonian sqrt sequencer over one shared
// FP adder and one shared FP divider.
module sqrt_iter_ctrl
  import sqrt_iter_ctrl_pkg::*;
#(
  parameter int          MAX_ITER = 32,
  parameter logic [31:0] EPS      = FP_EPS_DEFAULT,
  parameter int          IW       = 6
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [31:0]   n,
  output logic          busy,
  output logic          done,
  output logic [31:0]   root,
  output logic [IW-1:0] iter,
  output logic          err_neg,
  output logic          timeout,
  sqrt_iter_ctrl_if.master add_if,
  sqrt_iter_ctrl_if.master div_if
);

  localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);

  ctrl_state_e   state_q;
  logic [31:0]   n_q, x_q, y_q, d_q, s_q;
  logic [31:0]   root_q;
  logic [IW-1:0] iter_q;
  logic          busy_q, done_q, err_q, tmo_q;
  logic          add_go_q, div_go_q;
  logic [31:0]   add_a, add_b, add_res;
  logic [31:0]   div_a, div_b, div_res;
  logic          add_rdy, div_rdy;
  logic          conv;

  assign add_a = x_q;
  assign add_b = (state_q == S_SUB) ?
                 {~y_q[31], y_q[30:0]} : y_q;
  assign div_a = (state_q == S_RECIP) ? n_q : s_q;
  assign div_b = (state_q == S_RECIP) ? x_q : FP_TWO;
  // a negative difference means x has undershot y
  assign conv  = d_q[31] | mag_le(d_q, EPS);

  assign busy    = busy_q;
  assign done    = done_q;
  assign root    = root_q;
  assign iter    = iter_q;
  assign err_neg = err_q;
  assign timeout = tmo_q;

  fp_hs_port u_add (
    .CLK      (CLK),
    .RST      (RST),
    .go_i     (add_go_q),
    .a_i      (add_a),
    .b_i      (add_b),
    .result_o (add_res),
    .rdy_o    (add_rdy),
    .u        (add_if)
  );

  fp_hs_port u_div (
    .CLK      (CLK),
    .RST      (RST),
    .go_i     (div_go_q),
    .a_i      (div_a),
    .b_i      (div_b),
    .result_o (div_res),
    .rdy_o    (div_rdy),
    .u        (div_if)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      d_q      <= '0;
      s_q      <= '0;
      root_q   <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      add_go_q <= 1'b0;
      div_go_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      add_go_q <= 1'b0;
      div_go_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q     <= n;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            state_q <= S_CLASS;
          end
        end
        S_CLASS: begin
          iter_q <= '0;
          if (n_q[30:23] == 8'hFF ||
              n_q[30:0] == 31'd0) begin
            root_q  <= n_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (n_q[31]) begin
            err_q   <= 1'b1;
            root_q  <= FP_QNAN;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            if (mag_le(FP_ONE, n_q)) begin
              x_q <= n_q;
              y_q <= FP_ONE;
            end else begin
              x_q <= FP_ONE;
              y_q <= n_q;
            end
            add_go_q <= 1'b1;
            state_q  <= S_SUB;
          end
        end
        S_SUB: begin
          if (add_rdy) begin
            d_q     <= add_res;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (conv || iter_q == ITER_MAX) begin
            tmo_q   <= !conv;
            root_q  <= x_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            add_go_q <= 1'b1;
            state_q  <= S_ADD;
          end
        end
        S_ADD: begin
          if (add_rdy) begin
            s_q      <= add_res;
            div_go_q <= 1'b1;
            state_q  <= S_HALF;
          end
        end
        S_HALF: begin
          if (div_rdy) begin
            x_q      <= div_res;
            div_go_q <= 1'b1;
            state_q  <= S_RECIP;
          end
        end
        S_RECIP: begin
          if (div_rdy) begin
            y_q <= div_res;
            if (iter_q != ITER_MAX)
              iter_q <= iter_q + 1'b1;
            add_go_q <= 1'b1;
            state_q  <= S_SUB;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
// Bench: two sequencers against behavioural
// FP adder/divider models with random latency.
module tb_sqrt_iter_ctrl;
  import sqrt_iter_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic start = 1'b0, start2 = 1'b0;
  logic [31:0] n = '0, n2 = '0;
  logic busy, done, err_neg, timeout;
  logic busy2, done2, err_neg2, timeout2;
  logic [31:0] root, root2;
  logic [5:0] iter, iter2;

  sqrt_iter_ctrl_if add0();
  sqrt_iter_ctrl_if div0();
  sqrt_iter_ctrl_if add1();
  sqrt_iter_ctrl_if div1();

  sqrt_iter_ctrl #(.MAX_ITER(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .n(n),
    .busy(busy), .done(done), .root(root),
    .iter(iter), .err_neg(err_neg),
    .timeout(timeout),
    .add_if(add0), .div_if(div0)
  );

  sqrt_iter_ctrl #(.MAX_ITER(2)) dut2 (
    .CLK(CLK), .RST(RST), .start(start2), .n(n2),
    .busy(busy2), .done(done2), .root(root2),
    .iter(iter2), .err_neg(err_neg2),
    .timeout(timeout2),
    .add_if(add1), .div_if(div1)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023),
         f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [23:0] q;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (d[62:52] == 11'd0 || e <= 0)
      return {d[63], 31'd0};
    q = {1'b1, d[51:29]};
    if (d[28] && ((|d[27:0]) || q[0])) begin
      if (q == 24'hFFFFFF) begin
        q = 24'h800000;
        e++;
      end else q = q + 24'd1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e), q[22:0]};
  endfunction

  function automatic int ulpd(
    input logic [31:0] a, input logic [31:0] b);
    longint df;
    df = longint'({32'd0, a}) - longint'({32'd0, b});
    return int'(df < 0 ? -df : df);
  endfunction

  // unit models: index 0/2 adders, 1/3 dividers
  logic [3:0] m_astb, m_bstb, m_zack;
  logic [31:0] m_a [4];
  logic [31:0] m_b [4];
  logic [3:0] ack_a_q = '0, ack_b_q = '0;
  logic [3:0] zstb_q = '0, got_a = '0, got_b = '0;
  logic [3:0] pend = '0;
  logic [31:0] z_q [4];
  logic [31:0] la [4];
  logic [31:0] lb [4];
  int cnt_a [4];
  int cnt_b [4];
  int cnt_z [4];
  int ops [4];
  int stb_cyc = 0;

  assign m_astb = {div1.a_stb, add1.a_stb,
                   div0.a_stb, add0.a_stb};
  assign m_bstb = {div1.b_stb, add1.b_stb,
                   div0.b_stb, add0.b_stb};
  assign m_zack = {div1.z_ack, add1.z_ack,
                   div0.z_ack, add0.z_ack};
  assign m_a[0] = add0.a; assign m_b[0] = add0.b;
  assign m_a[1] = div0.a; assign m_b[1] = div0.b;
  assign m_a[2] = add1.a; assign m_b[2] = add1.b;
  assign m_a[3] = div1.a; assign m_b[3] = div1.b;
  assign add0.a_ack = ack_a_q[0];
  assign add0.b_ack = ack_b_q[0];
  assign add0.z_stb = zstb_q[0];
  assign add0.z     = z_q[0];
  assign div0.a_ack = ack_a_q[1];
  assign div0.b_ack = ack_b_q[1];
  assign div0.z_stb = zstb_q[1];
  assign div0.z     = z_q[1];
  assign add1.a_ack = ack_a_q[2];
  assign add1.b_ack = ack_b_q[2];
  assign add1.z_stb = zstb_q[2];
  assign add1.z     = z_q[2];
  assign div1.a_ack = ack_a_q[3];
  assign div1.b_ack = ack_b_q[3];
  assign div1.z_stb = zstb_q[3];
  assign div1.z     = z_q[3];

  initial begin
    for (int k = 0; k < 4; k++) begin
      ops[k] = 0; z_q[k] = '0;
      la[k] = '0; lb[k] = '0;
      cnt_a[k] = 0; cnt_b[k] = 0; cnt_z[k] = 0;
    end
  end

  always @(posedge CLK) begin
    if (|{m_astb[1:0], m_bstb[1:0]})
      stb_cyc <= stb_cyc + 1;
    if (RST) begin
      ack_a_q <= '0; ack_b_q <= '0; zstb_q <= '0;
      got_a <= '0; got_b <= '0; pend <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ack_a_q[k]) begin
          ack_a_q[k] <= 1'b0;
          la[k] <= m_a[k];
          got_a[k] <= 1'b1;
        end else if (m_astb[k] && !got_a[k]) begin
          if (cnt_a[k] == 0) ack_a_q[k] <= 1'b1;
          else cnt_a[k] <= cnt_a[k] - 1;
        end
        if (ack_b_q[k]) begin
          ack_b_q[k] <= 1'b0;
          lb[k] <= m_b[k];
          got_b[k] <= 1'b1;
        end else if (m_bstb[k] && !got_b[k]) begin
          if (cnt_b[k] == 0) ack_b_q[k] <= 1'b1;
          else cnt_b[k] <= cnt_b[k] - 1;
        end
        if (zstb_q[k]) begin
          if (m_zack[k]) begin
            zstb_q[k] <= 1'b0;
            ops[k] <= ops[k] + 1;
            cnt_a[k] <= int'($urandom_range(0, 5));
            cnt_b[k] <= int'($urandom_range(0, 5));
            cnt_z[k] <= int'($urandom_range(0, 5));
          end
        end else if (pend[k]) begin
          if (cnt_z[k] == 0) begin
            zstb_q[k] <= 1'b1;
            pend[k] <= 1'b0;
          end else cnt_z[k] <= cnt_z[k] - 1;
        end else if (got_a[k] && got_b[k]) begin
          got_a[k] <= 1'b0;
          got_b[k] <= 1'b0;
          pend[k] <= 1'b1;
          z_q[k] <= (k % 2 == 1) ?
            r2f(f2r(la[k]) / f2r(lb[k])) :
            r2f(f2r(la[k]) + f2r(lb[k]));
        end
      end
    end
  end

  typedef struct {
    logic [31:0] root;
    int tol;
    logic neg;
    logic tmo;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int vec = 0;
  int mis = 0;

  task automatic push(input logic [31:0] r,
                      input int tol,
                      input logic ng,
                      input logic tm);
    exp_t x;
    x.root = r; x.tol = tol; x.neg = ng; x.tmo = tm;
    sb.push_back(x);
  endtask

  task automatic run(input bit w,
                     input logic [31:0] v,
                     output int cyc);
    @(posedge CLK); #1;
    if (w) begin start2 = 1'b1; n2 = v; end
    else begin start = 1'b1; n = v; end
    @(posedge CLK); #1;
    start = 1'b0; start2 = 1'b0;
    cyc = 1;
    while (!(w ? done2 : done) && cyc < 4000) begin
      @(posedge CLK); #1;
      cyc++;
    end
    if (!(w ? done2 : done)) cyc = -1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge CLK);
    #1;
    vec++;
    if ({busy, done, err_neg, timeout} !== 4'b0) begin
      mis++;
      $display("FAIL reset_flags: got %b want 0000",
               {busy, done, err_neg, timeout});
    end
    vec++;
    if ({root, iter} !== 38'd0) begin
      mis++;
      $display("FAIL reset_data: got %h/%0d want 0/0",
               root, iter);
    end
    vec++;
    if ({add0.a_stb, add0.b_stb, add0.z_ack,
         div0.a_stb, div0.b_stb, div0.z_ack} !== 6'b0)
    begin
      mis++;
      $display("FAIL reset_hs: handshake outputs not 0");
    end
    RST = 1'b0;
  endtask

  task automatic check_sb(input string nm,
                          input int cyc);
    vec++;
    if (cyc < 0) begin
      mis++;
      $display("FAIL %s_done: no done in budget", nm);
    end
    e = sb.pop_front();
    vec++;
    if (ulpd(root, e.root) > e.tol) begin
      mis++;
      $display("FAIL %s_root: got %h want %h (+-%0d)",
               nm, root, e.root, e.tol);
    end
    vec++;
    if ({err_neg, timeout} !== {e.neg, e.tmo}) begin
      mis++;
      $display("FAIL %s_flags: got %b want %b",
               nm, {err_neg, timeout}, {e.neg, e.tmo});
    end
  endtask

  task automatic test_four;
    int c;
    push(32'h40000000, 1, 1'b0, 1'b0);
    run(1'b0, 32'h40800000, c);
    check_sb("four", c);
    vec++;
    if (iter == 6'd0 || iter >= 6'd32) begin
      mis++;
      $display("FAIL four_iter: got %0d want 1..31",
               iter);
    end
  endtask

  task automatic test_quarter;
    int c;
    push(32'h3F000000, 1, 1'b0, 1'b0);
    run(1'b0, 32'h3E800000, c);
    check_sb("quarter", c);
    vec++;
    if (iter == 6'd0) begin
      mis++;
      $display("FAIL quarter_iter: got 0 want >0");
    end
  endtask

  task automatic test_one;
    int c, a0, d0;
    a0 = ops[0]; d0 = ops[1];
    push(32'h3F800000, 0, 1'b0, 1'b0);
    run(1'b0, 32'h3F800000, c);
    check_sb("one", c);
    vec++;
    if (iter !== 6'd0) begin
      mis++;
      $display("FAIL one_iter: got %0d want 0", iter);
    end
    vec++;
    if (ops[0] - a0 != 1 || ops[1] - d0 != 0) begin
      mis++;
      $display("FAIL one_ops: got add=%0d div=%0d want 1/0",
               ops[0] - a0, ops[1] - d0);
    end
  endtask

  task automatic test_special;
    logic [31:0] vin [4];
    logic [31:0] vout [4];
    int c, s0;
    vin[0] = 32'hC0800000; vout[0] = FP_QNAN;
    vin[1] = 32'h00000000; vout[1] = 32'h00000000;
    vin[2] = 32'h80000000; vout[2] = 32'h80000000;
    vin[3] = 32'h7F800000; vout[3] = 32'h7F800000;
    for (int i = 0; i < 4; i++) begin
      s0 = stb_cyc;
      push(vout[i], 0, (i == 0), 1'b0);
      run(1'b0, vin[i], c);
      check_sb("special", c);
      vec++;
      if (c != 2) begin
        mis++;
        $display("FAIL special_lat: got %0d want 2", c);
      end
      vec++;
      if (stb_cyc != s0) begin
        mis++;
        $display("FAIL special_stb: got %0d stb cycles want 0",
                 stb_cyc - s0);
      end
    end
  endtask

  task automatic test_timeout;
    int c, extra;
    exp_t x;
    x.root = r2f(250001.25); x.tol = 2;
    x.neg = 1'b0; x.tmo = 1'b1;
    sb.push_back(x);
    @(posedge CLK); #1;
    start2 = 1'b1; n2 = 32'h49742400;
    @(posedge CLK); #1;
    start2 = 1'b0;
    vec++;
    if (busy2 !== 1'b1) begin
      mis++;
      $display("FAIL tmo_busy: got %b want 1", busy2);
    end
    repeat (3) @(posedge CLK);
    #1; start2 = 1'b1; n2 = 32'h40800000;
    @(posedge CLK); #1; start2 = 1'b0;
    c = 0;
    while (!done2 && c < 4000) begin
      @(posedge CLK); #1; c++;
    end
    e = sb.pop_front();
    vec++;
    if (!done2) begin
      mis++;
      $display("FAIL tmo_done: no done in budget");
    end
    vec++;
    if (ulpd(root2, e.root) > e.tol) begin
      mis++;
      $display("FAIL tmo_root: got %h want %h",
               root2, e.root);
    end
    vec++;
    if ({err_neg2, timeout2} !== {e.neg, e.tmo}) begin
      mis++;
      $display("FAIL tmo_flags: got %b want 01",
               {err_neg2, timeout2});
    end
    vec++;
    if (iter2 !== 6'd2) begin
      mis++;
      $display("FAIL tmo_iter: got %0d want 2", iter2);
    end
    extra = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done2 || busy2) extra++;
    end
    vec++;
    if (extra != 0) begin
      mis++;
      $display("FAIL tmo_ignore: got %0d busy cycles want 0",
               extra);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vin [4];
    logic [31:0] vout [4];
    int c;
    vin[0] = 32'hC0800000; vout[0] = FP_QNAN;
    vin[1] = 32'h41100000; vout[1] = 32'h40400000;
    vin[2] = 32'h41800000; vout[2] = 32'h40800000;
    vin[3] = 32'h40000000; vout[3] = 32'h3FB504F3;
    for (int i = 0; i < 4; i++)
      push(vout[i], (i == 0) ? 0 : 1, (i == 0), 1'b0);
    for (int i = 0; i < 4; i++) begin
      run(1'b0, vin[i], c);
      check_sb("b2b", c);
    end
  endtask

  task automatic test_reset_mid;
    int c;
    @(posedge CLK); #1;
    start = 1'b1; n = 32'h40800000;
    @(posedge CLK); #1;
    start = 1'b0;
    c = 0;
    while (!div0.a_stb && c < 500) begin
      @(posedge CLK); #1; c++;
    end
    vec++;
    if (!div0.a_stb) begin
      mis++;
      $display("FAIL rst_half: never reached HALF");
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    vec++;
    if ({busy, done, err_neg, timeout} !== 4'b0 ||
        {root, iter} !== 38'd0) begin
      mis++;
      $display("FAIL rst_mid_out: got %b %h %0d want 0",
               {busy, done, err_neg, timeout}, root, iter);
    end
    vec++;
    if ({add0.a_stb, add0.b_stb, div0.a_stb,
         div0.b_stb, div0.z_ack} !== 5'b0) begin
      mis++;
      $display("FAIL rst_mid_hs: handshake outputs not 0");
    end
    RST = 1'b0;
    push(32'h40000000, 1, 1'b0, 1'b0);
    run(1'b0, 32'h40800000, c);
    check_sb("rst_again", c);
  endtask

  initial begin
    test_reset;
    test_four;
    test_quarter;
    test_one;
    test_special;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, mis);
    $finish;
  end

endmodule
